obi_req_initiator: RTL and testbench
====================================

# obi_req_initiator

OBI initiator for the example testbench: accepts transfer commands from a sequencer port, drives OBI request and address-phase signals with optional programmable request stalls, tracks outstanding transactions, and returns each OBI response in order on a response port tagged read or write. It is the request side that talks to the memory model's response-stall FIFO, and it exercises the core-side request-phase behaviour that the response side never drives.

## Interface
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions (≥1).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; BE width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command available.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  address.
- cmd_be_i  in  DATA_WIDTH/8  byte enables.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- en_stall_i  in  1  enable request stalls.
- req_stall_i  in  4  idle cycles inserted before req_o (0–15).
- req_o  out  1  OBI request.
- gnt_i  in  1  OBI grant.
- addr_o, we_o, be_o, wdata_o  out  ADDR_WIDTH/1/BE/DATA_WIDTH  OBI address phase.
- rvalid_i  in  1  OBI response valid.
- rdata_i  in  DATA_WIDTH  OBI read data.
- rsp_valid_o  out  1  response pulse, one per transaction.
- rsp_we_o  out  1  transaction was a write.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  granted, unanswered count.
- err_o  out  1  sticky protocol error.

## Operation
- FSM states IDLE, STALL, REQ. Command fields and stall count (en_stall_i ? req_stall_i : 0) captured into a holding register on accept.
- cmd_ready_o = (state==IDLE) || (state==REQ && gnt_i).
- On accept: next state REQ if stall==0 and cnt_next < MAX_OUTSTANDING, else STALL. cnt_next = outstanding after this cycle's grant/retire.
- STALL: decrement stall counter to 0 (saturating); leave to REQ when counter==0 and outstanding < MAX_OUTSTANDING; otherwise hold.
- REQ: req_o=1, addr/we/be/wdata from holding register, held stable until gnt_i. On gnt_i: push we into tag FIFO (depth MAX_OUTSTANDING), go to IDLE unless a new command is accepted the same cycle (then apply accept rule).
- wdata_o driven 0 for reads; address-phase outputs 0 whenever req_o=0.
- rvalid_i with tag FIFO non-empty: pop tag; register rsp_valid_o=1, rsp_we_o=tag, rsp_rdata_o = tag ? 0 : rdata_i.
- rvalid_i with tag FIFO empty (including the grant cycle of the only transaction): err_o set, no pop, no rsp_valid_o.
- Grant and rvalid same cycle: push and pop both occur; count unchanged.
- Outstanding counter and tag pointers wrap modulo FIFO depth with an extra wrap bit for full/empty; grant cannot occur when full (FSM guarantees req_o=0).

## Timing
- Reset values: state IDLE, cmd_ready_o=1, req_o=0, address-phase outputs 0, rsp_valid_o=0, rsp_we_o=0, rsp_rdata_o=0, outstanding_o=0, err_o=0; tag FIFO emptied.
- Command accepted cycle N, stall 0, not full: req_o=1 in N+1. Stall k: req_o=1 in N+1+k.
- Back-to-back: grant in cycle M with new command accepted in M → req_o stays 1 in M+1 (if no stall, not full).
- rvalid_i in cycle R → rsp_valid_o in R+1, single cycle; no backpressure on response port.
- outstanding_o updates the cycle after grant/rvalid.
- err_o only cleared by reset. Reset mid-transaction drops all outstanding state; rvalid after reset release sets err_o.

## Test plan
- Read, stall 0, gnt_i same cycle req_o rises, rvalid_i 2 cycles later with rdata 0xDEADBEEF -> req_o one cycle, rsp_valid_o=1, rsp_we_o=0, rsp_rdata_o=0xDEADBEEF one cycle after rvalid.
- Write addr 0x100 be 0xF wdata 0x12345678, gnt_i held low 3 cycles -> req_o and address phase stable 4 cycles; response gives rsp_we_o=1, rsp_rdata_o=0.
- en_stall_i=1, req_stall_i=5 -> req_o first high 6 cycles after command accept; en_stall_i=0 same values -> 1 cycle.
- MAX_OUTSTANDING=2, three reads, gnt_i always 1, rvalid_i withheld -> two grants, outstanding_o=2, req_o low; first rvalid_i -> third req_o next cycle; responses in order with rsp_we tags matching.
- rvalid_i with outstanding_o=0 -> err_o=1 sticky, no rsp_valid_o; assert rst_i -> err_o=0, outputs at reset values.
- Grant of transaction B coinciding with rvalid for A -> outstanding_o unchanged at 1, A's response emitted, B retired by next rvalid.

Source files
------------

// File: rtl/obi_req_initiator.sv
// OBI request-side initiator: turns sequencer commands into OBI address-phase
// requests and returns each OBI response in order, tagged read or write.
module obi_req_initiator #(
  parameter int  MAX_OUTSTANDING = 2,
  parameter int  ADDR_WIDTH      = 32,
  parameter int  DATA_WIDTH      = 32,
  localparam int BE_WIDTH        = DATA_WIDTH / 8,
  localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BE_WIDTH-1:0]   cmd_be_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic                  en_stall_i,
  input  logic [3:0]            req_stall_i,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [BE_WIDTH-1:0]   be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  localparam int IDX_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, REQ = 2'd2} state_t;

  state_t                  state, state_next, accept_target;
  logic                    hold_we;
  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic [BE_WIDTH-1:0]     hold_be;
  logic [DATA_WIDTH-1:0]   hold_wdata;
  logic [3:0]              stall_cnt, stall_val;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [IDX_WIDTH-1:0]    wr_idx, rd_idx;
  logic                    wr_wrap, rd_wrap;
  logic [CNT_WIDTH-1:0]    cnt, cnt_next;
  logic                    fifo_empty, push, pop, accept;
  logic                    rsp_valid, rsp_we, err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  // Advance a tag pointer modulo the FIFO depth, flipping the wrap bit on rollover.
  function automatic logic [IDX_WIDTH:0] bump(input logic [IDX_WIDTH-1:0] idx, input logic wrap);
    if (idx == LAST_IDX) begin
      return {~wrap, {IDX_WIDTH{1'b0}}};
    end else begin
      return {wrap, idx + IDX_WIDTH'(1)};
    end
  endfunction

  assign req_o         = (state == REQ);
  assign push          = req_o && gnt_i;
  assign fifo_empty    = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign pop           = rvalid_i && !fifo_empty;
  assign cmd_ready_o   = (state == IDLE) || push;
  assign accept        = cmd_valid_i && cmd_ready_o;
  assign stall_val     = en_stall_i ? req_stall_i : 4'd0;
  assign accept_target = ((stall_val == 4'd0) && (cnt_next < MAX_CNT)) ? REQ : STALL;

  assign addr_o  = req_o ? hold_addr : {ADDR_WIDTH{1'b0}};
  assign we_o    = req_o && hold_we;
  assign be_o    = req_o ? hold_be : {BE_WIDTH{1'b0}};
  assign wdata_o = (req_o && hold_we) ? hold_wdata : {DATA_WIDTH{1'b0}};

  assign rsp_valid_o   = rsp_valid;
  assign rsp_we_o      = rsp_we;
  assign rsp_rdata_o   = rsp_rdata;
  assign outstanding_o = cnt;
  assign err_o         = err;

  // Outstanding count as it will be after this cycle's grant and retire.
  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      cnt_next = cnt - CNT_WIDTH'(1);
    end else begin
      cnt_next = cnt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = accept_target;
        else        state_next = IDLE;
      end
      REQ: begin
        if (accept)     state_next = accept_target;
        else if (gnt_i) state_next = IDLE;
        else            state_next = REQ;
      end
      STALL: begin
        if ((stall_cnt == 4'd0) && (cnt_next < MAX_CNT)) state_next = REQ;
        else                                            state_next = STALL;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Holding register and stall counter; k stall cycles load k-1 so REQ lands k cycles late.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_we    <= 1'b0;
      hold_addr  <= {ADDR_WIDTH{1'b0}};
      hold_be    <= {BE_WIDTH{1'b0}};
      hold_wdata <= {DATA_WIDTH{1'b0}};
      stall_cnt  <= 4'd0;
    end else if (accept) begin
      hold_we    <= cmd_we_i;
      hold_addr  <= cmd_addr_i;
      hold_be    <= cmd_be_i;
      hold_wdata <= cmd_wdata_i;
      stall_cnt  <= (stall_val == 4'd0) ? 4'd0 : stall_val - 4'd1;
    end else if ((state == STALL) && (stall_cnt != 4'd0)) begin
      stall_cnt  <= stall_cnt - 4'd1;
    end
  end

  // Tag FIFO and outstanding counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_mem <= {MAX_OUTSTANDING{1'b0}};
      wr_idx  <= {IDX_WIDTH{1'b0}};
      wr_wrap <= 1'b0;
      rd_idx  <= {IDX_WIDTH{1'b0}};
      rd_wrap <= 1'b0;
      cnt     <= {CNT_WIDTH{1'b0}};
    end else begin
      if (push) begin
        tag_mem[wr_idx]   <= hold_we;
        {wr_wrap, wr_idx} <= bump(wr_idx, wr_wrap);
      end
      if (pop) begin
        {rd_wrap, rd_idx} <= bump(rd_idx, rd_wrap);
      end
      cnt <= cnt_next;
    end
  end

  // Registered response port and sticky error on an unmatched rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= {DATA_WIDTH{1'b0}};
      err       <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_we    <= tag_mem[rd_idx];
        rsp_rdata <= tag_mem[rd_idx] ? {DATA_WIDTH{1'b0}} : rdata_i;
      end
      if (rvalid_i && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_req_initiator.sv
// Directed bench for obi_req_initiator; responses are checked by a scoreboard monitor.
module tb_obi_req_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        en_stall;
  logic [3:0]  req_stall;
  logic        req, gnt, we;
  logic [31:0] addr, wdata, rdata, rsp_rdata;
  logic [3:0]  be;
  logic        rvalid, rsp_valid, rsp_we;
  logic [1:0]  outstanding;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [31:0] rd_q[$];

  obi_req_initiator #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_be_i(cmd_be), .cmd_wdata_i(cmd_wdata),
    .en_stall_i(en_stall), .req_stall_i(req_stall),
    .req_o(req), .gnt_i(gnt), .addr_o(addr), .we_o(we), .be_o(be), .wdata_o(wdata),
    .rvalid_i(rvalid), .rdata_i(rdata),
    .rsp_valid_o(rsp_valid), .rsp_we_o(rsp_we), .rsp_rdata_o(rsp_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and record what its response must look like.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] wd, input logic [31:0] rd);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_addr  = a;
    cmd_be    = b;
    cmd_wdata = wd;
    exp_q.push_back({w, w ? 32'h0 : rd});
    rd_q.push_back(w ? 32'hBAD0BAD0 : rd);
  endtask

  task automatic rsp_pulse();
    rvalid = 1'b1;
    rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
    tick();
    rvalid = 1'b0;
    rdata  = 32'h0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    #1;
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    chk({tag, "_phase"}, {req, we, be, addr, wdata}, 70'h0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_we, rsp_rdata}, 34'h0);
    chk({tag, "_outst_err"}, {outstanding, err}, 3'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=we%0b/%0h required=none", rsp_we, rsp_rdata);
      end else begin
        chk("rsp_payload", {rsp_we, rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int cycles;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_be = 4'h0;
    cmd_wdata = 32'h0; en_stall = 1'b0; req_stall = 4'd0; gnt = 1'b0;
    rvalid = 1'b0; rdata = 32'h0;
    tick();
    do_reset("reset");

    // Read, granted in the cycle req rises, answered two cycles after grant.
    send_cmd(1'b0, 32'h40, 4'hF, 32'h0, 32'hDEADBEEF);
    tick();
    cmd_valid = 1'b0;
    chk("rd_req_phase", {req, we, be, addr, wdata}, {1'b1, 1'b0, 4'hF, 32'h40, 32'h0});
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("rd_req_one_cycle", req, 1'b0);
    chk("rd_outst_1", outstanding, 2'd1);
    tick();
    rsp_pulse();
    chk("rd_outst_0", outstanding, 2'd0);
    tick();

    // Write held off by three cycles of gnt low.
    send_cmd(1'b1, 32'h100, 4'hF, 32'h12345678, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_phase_stable", {req, we, be, addr, wdata}, {1'b1, 1'b1, 4'hF, 32'h100, 32'h12345678});
      if (i == 3) gnt = 1'b1;
      tick();
    end
    gnt = 1'b0;
    chk("wr_req_drop", {req, addr}, 33'h0);
    rsp_pulse();
    tick();

    // Programmable stall of 5, then the same value with stalls disabled.
    for (int pass = 0; pass < 2; pass++) begin
      en_stall  = (pass == 0);
      req_stall = 4'd5;
      send_cmd(1'b0, 32'h200 + 32'(pass), 4'h3, 32'h0, 32'hC0DE0000 + 32'(pass));
      tick();
      cmd_valid = 1'b0;
      cycles = 1;
      while (!req && cycles < 40) begin
        tick();
        cycles++;
      end
      chk(pass == 0 ? "stall5_latency" : "nostall_latency", cycles, (pass == 0) ? 6 : 1);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      rsp_pulse();
      tick();
    end
    en_stall = 1'b0;
    req_stall = 4'd0;

    // Three back-to-back commands with responses withheld: the third waits for room.
    gnt = 1'b1;
    send_cmd(1'b0, 32'h300, 4'hF, 32'h0, 32'h11111111);
    tick();
    chk("b2b_ready_on_gnt", {req, cmd_ready}, 2'b11);
    send_cmd(1'b1, 32'h304, 4'h1, 32'h22222222, 32'h0);
    tick();
    chk("b2b_req_stays", req, 1'b1);
    send_cmd(1'b0, 32'h308, 4'hF, 32'h0, 32'h33333333);
    tick();
    cmd_valid = 1'b0;
    chk("full_state", {outstanding, req}, {2'd2, 1'b0});
    tick();
    tick();
    chk("full_hold", {outstanding, req, cmd_ready}, {2'd2, 1'b0, 1'b0});
    rsp_pulse();
    chk("third_req_after_rvalid", {req, addr, outstanding}, {1'b1, 32'h308, 2'd1});
    tick();
    gnt = 1'b0;
    chk("third_granted", {req, outstanding}, {1'b0, 2'd2});
    rsp_pulse();
    rsp_pulse();
    chk("b2b_drained", outstanding, 2'd0);
    tick();

    // Unmatched rvalid sets a sticky error and emits no response.
    rvalid = 1'b1;
    rdata  = 32'hFFFF0000;
    tick();
    rvalid = 1'b0;
    chk("err_set", {err, rsp_valid}, 2'b10);
    tick();
    tick();
    chk("err_sticky", err, 1'b1);
    do_reset("err_reset");

    // Reset mid-transaction drops the outstanding read; its late rvalid is an error.
    send_cmd(1'b0, 32'h400, 4'hF, 32'h0, 32'h44444444);
    tick();
    cmd_valid = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("mid_outst_1", outstanding, 2'd1);
    do_reset("mid_reset");
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("late_rvalid_err", {err, rsp_valid, outstanding}, {1'b1, 1'b0, 2'd0});
    do_reset("final_reset");

    // Grant of B in the same cycle as A's rvalid keeps the count at 1.
    send_cmd(1'b0, 32'h500, 4'hF, 32'h0, 32'hA5A5A5A5);
    tick();
    cmd_valid = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    send_cmd(1'b1, 32'h504, 4'hC, 32'h5A5A5A5A, 32'h0);
    tick();
    cmd_valid = 1'b0;
    gnt    = 1'b1;
    rvalid = 1'b1;
    rdata  = rd_q.pop_front();
    tick();
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'h0;
    chk("gnt_rvalid_same_cycle", {outstanding, req}, {2'd1, 1'b0});
    rsp_pulse();
    chk("b_retired", {outstanding, err}, {2'd0, 1'b0});
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
